// File: rtl/ifid_skid_stage.sv
// ifid_skid_stage
//   Fetch/decode pipeline boundary register with a valid/ready handshake,
//   a two-entry skid buffer (main + skid), flush-to-bubble and saturating
//   stall/flush event counters. in_ready is registered, so there is no
//   combinational path from decode stall back to fetch.
//
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   in_valid/in_ready fetch-side handshake (in_ready registered)
//   in_pc, in_instr   PC-plus-4 and instruction offered by fetch
//   flush             redirect kill; discards held and offered entries
//   out_valid/out_ready decode-side handshake (out_valid registered)
//   out_pc, out_instr registered entry presented to decode (bubble when empty)
//   stall_cnt         saturating count of out_valid & ~out_ready cycles
//   flush_cnt         saturating count of flush cycles
module ifid_skid_stage #(
    parameter int unsigned          PC_W      = 32,
    parameter int unsigned          INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [PC_W-1:0]    main_pc_n, skid_pc, skid_pc_n;
    logic [INSTR_W-1:0] main_instr_n, skid_instr, skid_instr_n;
    logic               in_ready_n, out_valid_n;
    logic [CNT_W-1:0]   stall_cnt_n, flush_cnt_n;
    logic               in_fire, out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= EMPTY;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_instr  <= NOP_INSTR;
            skid_pc    <= '0;
            skid_instr <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state      <= state_n;
            in_ready   <= in_ready_n;
            out_valid  <= out_valid_n;
            out_pc     <= main_pc_n;
            out_instr  <= main_instr_n;
            skid_pc    <= skid_pc_n;
            skid_instr <= skid_instr_n;
            stall_cnt  <= stall_cnt_n;
            flush_cnt  <= flush_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        main_pc_n    = out_pc;
        main_instr_n = out_instr;
        skid_pc_n    = skid_pc;
        skid_instr_n = skid_instr;

        if (flush) begin
            state_n = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_pc_n    = in_pc;
                        main_instr_n = in_instr;
                        state_n      = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_pc_n    = in_pc;
                        main_instr_n = in_instr;
                    end else if (out_fire) begin
                        state_n = EMPTY;
                    end else if (in_fire) begin
                        skid_pc_n    = in_pc;
                        skid_instr_n = in_instr;
                        state_n      = FULL;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_pc_n    = skid_pc;
                        main_instr_n = skid_instr;
                        state_n      = ONE;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end

        if (state_n == EMPTY) begin
            main_pc_n    = '0;
            main_instr_n = NOP_INSTR;
        end

        // Handshake flags are registered copies decoded from the next state.
        in_ready_n  = (state_n != FULL);
        out_valid_n = (state_n != EMPTY);

        stall_cnt_n = stall_cnt;
        if (out_valid && !out_ready && (stall_cnt != '1))
            stall_cnt_n = stall_cnt + 1'b1;

        flush_cnt_n = flush_cnt;
        if (flush && (flush_cnt != '1))
            flush_cnt_n = flush_cnt + 1'b1;
    end

endmodule

// File: tb/tb_ifid_skid_stage.sv
module tb_ifid_skid_stage;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 4;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    logic               Clk = 1'b0;
    logic               Reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [PC_W-1:0]    in_pc, out_pc;
    logic [INSTR_W-1:0] in_instr, out_instr;
    logic [CNT_W-1:0]   stall_cnt, flush_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [PC_W+INSTR_W-1:0] sb_q[$];

    ifid_skid_stage #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic offer(input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = ins;
    endtask

    // Scoreboard: inputs are stable at the falling edge, so the handshakes
    // that the coming rising edge will act on are visible here.
    always @(negedge Clk) begin
        logic [PC_W+INSTR_W-1:0] e;
        if (Reset) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_pc", 64'(out_pc), 64'(e[PC_W+INSTR_W-1:INSTR_W]));
                    check("sb_instr", 64'(out_instr), 64'(e[INSTR_W-1:0]));
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back({in_pc, in_instr});
        end
    end

    initial begin
        Reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        Reset = 1'b0;

        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_pc",    64'(out_pc),    64'd0);
        check("rst_out_instr", 64'(out_instr), 64'(NOP));
        check("rst_stall",     64'(stall_cnt), 64'd0);
        check("rst_flush",     64'(flush_cnt), 64'd0);

        // Stream with decode always ready: 1-cycle latency, full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(32'(4 * (i + 1)), 32'hA + 32'(i));
            tick();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_ready", 64'(in_ready),  64'd1);
            check("stream_pc",    64'(out_pc),    64'(4 * (i + 1)));
            check("stream_instr", 64'(out_instr), 64'(32'hA + 32'(i)));
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_instr", 64'(out_instr), 64'(NOP));

        // Skid fill then drain.
        out_ready = 1'b0;
        offer(32'd4, 32'hA);  tick();
        check("fill1_ready", 64'(in_ready), 64'd1);
        offer(32'd8, 32'hB);  tick();
        check("fill2_ready", 64'(in_ready), 64'd0);
        offer(32'd12, 32'hC); tick();
        check("full_hold_ready", 64'(in_ready), 64'd0);
        check("full_hold_pc",    64'(out_pc),   64'd4);
        check("stall_two",       64'(stall_cnt), 64'd2);
        out_ready = 1'b1;
        tick();
        check("skid_to_main_pc", 64'(out_pc),   64'd8);
        check("skid_ready",      64'(in_ready), 64'd1);
        tick();
        check("last_pc", 64'(out_pc), 64'd12);
        in_valid = 1'b0;
        tick();
        check("skid_drained", 64'(out_valid), 64'd0);

        // Flush while FULL, with an entry offered.
        out_ready = 1'b0;
        offer(32'd20, 32'h14); tick();
        offer(32'd24, 32'h18); tick();
        check("pre_flush_full", 64'(in_ready), 64'd0);
        offer(32'd16, 32'h10); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid",  64'(out_valid), 64'd0);
        check("flush_pc",     64'(out_pc),    64'd0);
        check("flush_instr",  64'(out_instr), 64'(NOP));
        check("flush_ready",  64'(in_ready),  64'd1);
        check("flush_cnt1",   64'(flush_cnt), 64'd1);
        check("stall_in_flush", 64'(stall_cnt), 64'd4);

        // Flush in ONE while fetch handshakes: offered entry dropped.
        offer(32'd28, 32'h1C); tick();
        offer(32'd32, 32'h20); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_one_valid", 64'(out_valid), 64'd0);
        check("flush_cnt2",      64'(flush_cnt), 64'd2);
        tick();
        check("flush_drop_stays", 64'(out_valid), 64'd0);

        // Stall counter saturation at 2^CNT_W-1.
        offer(32'd36, 32'h24); tick();
        in_valid = 1'b0;
        repeat (20) tick();
        check("stall_sat", 64'(stall_cnt), 64'd15);
        tick();
        check("stall_sat_hold", 64'(stall_cnt), 64'd15);
        check("flush_cnt_kept", 64'(flush_cnt), 64'd2);
        out_ready = 1'b1; tick();
        check("sat_drain", 64'(out_valid), 64'd0);

        // Reset wins over flush.
        out_ready = 1'b0;
        offer(32'd40, 32'h28); tick();
        in_valid = 1'b0;
        Reset = 1'b1; flush = 1'b1; tick();
        Reset = 1'b0; flush = 1'b0;
        check("rf_valid", 64'(out_valid), 64'd0);
        check("rf_ready", 64'(in_ready),  64'd1);
        check("rf_pc",    64'(out_pc),    64'd0);
        check("rf_instr", 64'(out_instr), 64'(NOP));
        check("rf_flush", 64'(flush_cnt), 64'd0);
        check("rf_stall", 64'(stall_cnt), 64'd0);

        tick();
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifid_skid_stage.md
# ifid_skid_stage

Parametrised fetch/decode pipeline boundary register with a valid/ready handshake, a two-entry skid buffer, flush-to-bubble and saturating stall/flush event counters. It sits between the fetch stage (PC adder and instruction memory) and decode. It replaces the fixed 32-bit hold/flush register with full-throughput back-pressure: upstream ready is registered, so no combinational path runs from decode stall to fetch.

## Interface
Parameters:
- PC_W, 32, width of the PC-plus-4 field
- INSTR_W, 32, width of the instruction field
- NOP_INSTR, 0 (INSTR_W bits), instruction encoding driven when no valid entry is presented (bubble)
- CNT_W, 16, width of each event counter

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high
- in_valid  in  1  fetch offers in_pc/in_instr
- in_ready  out  1  buffer accepts this cycle; registered
- in_pc  in  PC_W  PC-plus-4 from fetch
- in_instr  in  INSTR_W  fetched instruction
- flush  in  1  branch-taken / redirect kill; discards all held and offered entries
- out_valid  out  1  decode-side entry valid; registered
- out_ready  in  1  decode consumes this cycle
- out_pc  out  PC_W  PC-plus-4 to decode; registered
- out_instr  out  INSTR_W  instruction to decode; registered
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating
- flush_cnt  out  CNT_W  cycles with flush=1; saturating

## Operation
- Storage: a main entry that drives out_* directly, and a skid entry.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State machine with three states:
  - EMPTY: no entry held
  - ONE: main entry valid
  - FULL: main and skid entries both valid
- in_ready = (state != FULL). out_valid = (state != EMPTY).
- Priority per edge: Reset > flush > handshake.
- Transitions when neither Reset nor flush is asserted:
  - EMPTY, in_fire: main <= in; go to ONE.
  - ONE, in_fire & out_fire: main <= in; stay in ONE.
  - ONE, out_fire only: go to EMPTY.
  - ONE, in_fire only: skid <= in; go to FULL.
  - ONE, neither: hold.
  - FULL, out_fire: main <= skid; go to ONE. in_fire is impossible because in_ready=0.
  - FULL, no out_fire: hold both entries.
- Bubble encoding: whenever the next state is EMPTY, out_pc <= 0 and out_instr <= NOP_INSTR.
- Flush:
  - Next state is EMPTY with bubble outputs.
  - An entry offered in the flush cycle is dropped, even if in_valid=1. in_ready stays as computed from the current state, so fetch sees a handshake, but the data is discarded.
  - out_fire in the flush cycle still counts as consumed by decode.
- Ordering: entries leave in arrival order; none is duplicated or lost, except by flush.
- Counters:
  - Each counter adds 1 per qualifying cycle and holds at 2^CNT_W-1.
  - A stall cycle that coincides with flush still counts.
  - Neither counter clears on flush.

## Timing
- Reset values:
  - state EMPTY, so out_valid=0 and in_ready=1
  - out_pc=0, out_instr=NOP_INSTR
  - skid contents=0
  - stall_cnt=0, flush_cnt=0
- Latency: in_fire at edge N gives out_valid=1 with that data after edge N, i.e. 1 cycle.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Back-pressure: in_ready drops 1 cycle after the first unconsumed in_fire. The skid entry absorbs the transfer already in flight.
- in_ready, out_valid, out_pc and out_instr are pure register outputs; none depends combinationally on any input.
- Reset or flush asserted mid-transfer: it takes effect at that edge, and the outputs show a bubble the next cycle.

## Test plan
- Reset then stream: pulse Reset; feed pc=4,8,12 with instr=0xA,0xB,0xC and out_ready=1 -> out_valid=0 and out_instr=0 in the first cycle after reset; then (4,0xA),(8,0xB),(12,0xC) on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Skid fill/drain: hold out_ready=0 while in_valid=1 offers pc=4,8,12 -> pc=4 and pc=8 accepted; in_ready=0 from the third cycle; pc=12 held off. Release out_ready -> outputs 4,8,12 in order with no duplicates.
- Flush in FULL: with both entries valid, assert flush with in_valid=1 pc=16 -> next cycle out_valid=0, out_pc=0, out_instr=NOP_INSTR, in_ready=1; pc=16 never appears on the outputs; flush_cnt=1.
- Stall counter saturation: CNT_W=4; hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reads 15 and stays 15; Reset returns it to 0.
- Simultaneous in/out in ONE: main=(4,0xA); in pc=8 and out_ready=1 in the same cycle -> next cycle out=(8,0xB), state ONE, in_ready=1, skid unused.
- Reset over flush: assert Reset and flush in the same cycle -> all outputs at reset values; flush_cnt=0.
